// File: rtl/conv_pass_scheduler.sv
// conv_pass_scheduler: pass/tap sequencer for the P-lane 1-D convolution datapath.
// In: clk, reset, x_full, op_space. Out: per-lane x and filter tap addresses,
// en_acc/clr_acc, valid_op/start_addr/lane_mask per pass, x_release, all_done.
module conv_pass_scheduler #(
  parameter int ADDRX = 6,
  parameter int ADDRF = 6,
  parameter int LENX  = 64,
  parameter int LENF  = 33,
  parameter int P     = 4,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x_full,
  input  logic             op_space,
  output logic [ADDRX-1:0] m_addr_read_x [P],
  output logic [ADDRF-1:0] m_addr_read_f,
  output logic             en_acc,
  output logic             clr_acc,
  output logic             valid_op,
  output logic [ADDRX-1:0] start_addr,
  output logic [P-1:0]     lane_mask,
  output logic             x_release,
  output logic             all_done
);

  // One extra bit so base+i+k never wraps before the compare.
  localparam int CW = ADDRX + 1;
  localparam logic [CW-1:0] SIZE_C = CW'(LENX - LENF + 1);
  localparam logic [CW-1:0] LAST_K = CW'(LENF - 1);
  localparam logic [CW-1:0] MAXX   = CW'(LENX - 1);
  localparam logic [CW-1:0] STEP   = CW'(P);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN
  } state_t;

  typedef struct packed {
    logic             issue;
    logic             first;
    logic             last;
    logic             fin;
    logic [ADDRX-1:0] base;
    logic [P-1:0]     mask;
  } tap_t;

  state_t           state_q;
  logic [CW-1:0]    base_q;
  logic [CW-1:0]    k_q;
  logic             armed_q;
  tap_t             pipe_q [LAT];
  logic             valid_q;
  logic             done_q;
  logic             rel_q;
  logic [ADDRX-1:0] start_q;
  logic [P-1:0]     mask_q;

  logic             issuing;
  logic             last_tap;
  logic             more;
  logic [CW-1:0]    sum_w [P];
  tap_t             tap_w;

  assign issuing  = (state_q == ISSUE);
  assign last_tap = issuing && (k_q == LAST_K);
  assign more     = (base_q + STEP) < SIZE_C;

  always_comb begin
    tap_w       = '0;
    tap_w.issue = issuing;
    tap_w.first = issuing && (k_q == '0);
    tap_w.last  = last_tap;
    tap_w.fin   = last_tap && !more;
    tap_w.base  = base_q[ADDRX-1:0];
    for (int i = 0; i < P; i++) begin
      sum_w[i]      = base_q + CW'(i) + k_q;
      tap_w.mask[i] = (base_q + CW'(i)) < SIZE_C;
      // Lanes past the end of a partial pass are clamped to the last x word.
      if (!issuing)
        m_addr_read_x[i] = '0;
      else if (sum_w[i] > MAXX)
        m_addr_read_x[i] = MAXX[ADDRX-1:0];
      else
        m_addr_read_x[i] = sum_w[i][ADDRX-1:0];
    end
  end

  assign m_addr_read_f = issuing ? ADDRF'(k_q) : '0;
  assign en_acc        = pipe_q[LAT-1].issue;
  assign clr_acc       = pipe_q[LAT-1].first;
  assign valid_op      = valid_q;
  assign all_done      = done_q;
  assign x_release     = rel_q;
  assign start_addr    = start_q;
  assign lane_mask     = mask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      k_q     <= '0;
      armed_q <= 1'b1;
      for (int j = 0; j < LAT; j++)
        pipe_q[j] <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      rel_q   <= 1'b0;
      start_q <= '0;
      mask_q  <= '0;
    end else begin
      pipe_q[0] <= tap_w;
      for (int j = 1; j < LAT; j++)
        pipe_q[j] <= pipe_q[j-1];
      // Accumulator is registered: result shows one cycle after last en_acc.
      valid_q <= pipe_q[LAT-1].last;
      done_q  <= pipe_q[LAT-1].last && pipe_q[LAT-1].fin;
      if (pipe_q[LAT-1].last) begin
        start_q <= pipe_q[LAT-1].base;
        mask_q  <= pipe_q[LAT-1].mask;
      end
      rel_q <= 1'b0;
      if (!x_full)
        armed_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          base_q <= '0;
          k_q    <= '0;
          if (x_full && armed_q)
            state_q <= op_space ? ISSUE : WAIT;
        end
        ISSUE: begin
          if (k_q == LAST_K) begin
            if (more) begin
              base_q  <= base_q + STEP;
              k_q     <= '0;
              state_q <= op_space ? ISSUE : WAIT;
            end else begin
              state_q <= DRAIN;
              rel_q   <= 1'b1;
              armed_q <= 1'b0;
            end
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        WAIT: begin
          k_q <= '0;
          if (op_space)
            state_q <= ISSUE;
        end
        DRAIN: begin
          if (done_q)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pass_scheduler.sv
// tb_conv_pass_scheduler: directed bench for conv_pass_scheduler.
// Three instances: defaults (A), LENF=30 (B), LAT=3 (C).
module tb_conv_pass_scheduler;

  typedef struct {
    int rel;
    int start;
    int mask;
    int done;
  } ev_t;

  typedef struct {
    int dut;
    int rel;
    int lane;
    int xa;
    int fa;
  } probe_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic       rstA = 1'b1, xfA = 1'b0, opA = 1'b0;
  logic [5:0] axA [4];
  logic [5:0] afA, stA;
  logic       enA, clrA, vA, relA, doneA;
  logic [3:0] mkA;

  logic       rstB = 1'b1, xfB = 1'b0, opB = 1'b0;
  logic [5:0] axB [4];
  logic [5:0] afB, stB;
  logic       enB, clrB, vB, relB, doneB;
  logic [3:0] mkB;

  logic       rstC = 1'b1, xfC = 1'b0, opC = 1'b0;
  logic [5:0] axC [4];
  logic [5:0] afC, stC;
  logic       enC, clrC, vC, relC, doneC;
  logic [3:0] mkC;

  conv_pass_scheduler u_a (
    .clk(clk), .reset(rstA), .x_full(xfA), .op_space(opA),
    .m_addr_read_x(axA), .m_addr_read_f(afA),
    .en_acc(enA), .clr_acc(clrA), .valid_op(vA),
    .start_addr(stA), .lane_mask(mkA),
    .x_release(relA), .all_done(doneA)
  );

  conv_pass_scheduler #(.LENF(30)) u_b (
    .clk(clk), .reset(rstB), .x_full(xfB), .op_space(opB),
    .m_addr_read_x(axB), .m_addr_read_f(afB),
    .en_acc(enB), .clr_acc(clrB), .valid_op(vB),
    .start_addr(stB), .lane_mask(mkB),
    .x_release(relB), .all_done(doneB)
  );

  conv_pass_scheduler #(.LAT(3)) u_c (
    .clk(clk), .reset(rstC), .x_full(xfC), .op_space(opC),
    .m_addr_read_x(axC), .m_addr_read_f(afC),
    .en_acc(enC), .clr_acc(clrC), .valid_op(vC),
    .start_addr(stC), .lane_mask(mkC),
    .x_release(relC), .all_done(doneC)
  );

  int baseA = 0, baseB = 0, baseC = 0;
  ev_t gotA[$], gotB[$], gotC[$];
  int relqA[$], relqB[$], relqC[$];
  int clrqC[$];
  int enCntA = 0;

  function automatic ev_t mk(int r, int s, int m, int d);
    ev_t e;
    e.rel = r; e.start = s; e.mask = m; e.done = d;
    return e;
  endfunction

  always @(negedge clk) begin
    if (vA) gotA.push_back(mk(cyc - baseA, int'(stA), int'(mkA), int'(doneA)));
    if (vB) gotB.push_back(mk(cyc - baseB, int'(stB), int'(mkB), int'(doneB)));
    if (vC) gotC.push_back(mk(cyc - baseC, int'(stC), int'(mkC), int'(doneC)));
    if (relA) relqA.push_back(cyc - baseA);
    if (relB) relqB.push_back(cyc - baseB);
    if (relC) relqC.push_back(cyc - baseC);
    if (clrC) clrqC.push_back(cyc - baseC);
    if (enA) enCntA++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cmp_ev(string nm, input ev_t got[$], int from, input ev_t exp[$]);
    int n;
    n = got.size() - from;
    chk({nm, " valid_op count"}, n, exp.size());
    for (int i = 0; i < exp.size() && i < n; i++) begin
      chk($sformatf("%s pass%0d cycle", nm, i), got[from+i].rel, exp[i].rel);
      chk($sformatf("%s pass%0d start_addr", nm, i), got[from+i].start, exp[i].start);
      chk($sformatf("%s pass%0d lane_mask", nm, i), got[from+i].mask, exp[i].mask);
      chk($sformatf("%s pass%0d all_done", nm, i), got[from+i].done, exp[i].done);
    end
  endtask

  function automatic int qat(input int q[$], int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  function automatic int axv(int d, int l);
    case (d)
      0: return int'(axA[l]);
      1: return int'(axB[l]);
      default: return int'(axC[l]);
    endcase
  endfunction

  function automatic int afv(int d);
    case (d)
      0: return int'(afA);
      1: return int'(afB);
      default: return int'(afC);
    endcase
  endfunction

  task automatic chk_zero_a(string nm);
    chk({nm, " en_acc"}, int'(enA), 0);
    chk({nm, " clr_acc"}, int'(clrA), 0);
    chk({nm, " valid_op"}, int'(vA), 0);
    chk({nm, " all_done"}, int'(doneA), 0);
    chk({nm, " x_release"}, int'(relA), 0);
    chk({nm, " start_addr"}, int'(stA), 0);
    chk({nm, " lane_mask"}, int'(mkA), 0);
    chk({nm, " addr_f"}, int'(afA), 0);
    chk({nm, " addr_x0"}, int'(axA[0]), 0);
    chk({nm, " addr_x3"}, int'(axA[3]), 0);
  endtask

  initial begin
    probe_t pr[$];
    ev_t expA[$], expB[$], expC[$], exp1[$];
    int iA, iB, iC, rA, rB, rC, cC, en0, stall_err;

    // Address probes for the free-running first run (rel cycle, lane, x addr, f addr).
    pr.push_back('{0, 1, 3, 3, 0});
    pr.push_back('{0, 33, 3, 35, 32});
    pr.push_back('{0, 34, 0, 4, 0});
    pr.push_back('{0, 264, 3, 63, 32});
    pr.push_back('{0, 265, 0, 0, 0});
    pr.push_back('{1, 241, 0, 32, 0});
    pr.push_back('{1, 269, 3, 63, 28});
    pr.push_back('{1, 270, 3, 63, 29});
    pr.push_back('{1, 270, 2, 63, 29});
    pr.push_back('{1, 270, 1, 62, 29});
    pr.push_back('{2, 39, 2, 11, 5});
    pr.push_back('{2, 1, 3, 3, 0});

    for (int n = 0; n < 8; n++)
      expA.push_back(mk(35 + 33*n, 4*n, 15, (n == 7) ? 1 : 0));
    for (int n = 0; n < 9; n++)
      expB.push_back(mk(32 + 30*n, 4*n, (n == 8) ? 7 : 15, (n == 8) ? 1 : 0));
    for (int n = 0; n < 8; n++)
      expC.push_back(mk(37 + 33*n, 4*n, 15, (n == 7) ? 1 : 0));

    repeat (3) step();
    chk_zero_a("reset");
    chk("reset B valid_op", int'(vB), 0);
    chk("reset C en_acc", int'(enC), 0);

    // Run 1: all three instances, op_space always 1.
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
    xfA = 1'b1; xfB = 1'b1; xfC = 1'b1;
    opA = 1'b1; opB = 1'b1; opC = 1'b1;
    baseA = cyc; baseB = cyc; baseC = cyc;
    iA = gotA.size(); iB = gotB.size(); iC = gotC.size();
    rA = relqA.size(); rB = relqB.size(); rC = relqC.size();
    cC = clrqC.size(); en0 = enCntA;
    for (int r = 1; r <= 300; r++) begin
      step();
      for (int p = 0; p < pr.size(); p++) begin
        if (pr[p].rel == r) begin
          chk($sformatf("probe d%0d r%0d x%0d", pr[p].dut, r, pr[p].lane),
              axv(pr[p].dut, pr[p].lane), pr[p].xa);
          chk($sformatf("probe d%0d r%0d f", pr[p].dut, r),
              afv(pr[p].dut), pr[p].fa);
        end
      end
    end
    cmp_ev("A run", gotA, iA, expA);
    cmp_ev("B run", gotB, iB, expB);
    cmp_ev("C run", gotC, iC, expC);
    chk("A x_release count", relqA.size() - rA, 1);
    chk("A x_release cycle", qat(relqA, rA), 265);
    chk("B x_release cycle", qat(relqB, rB), 271);
    chk("C x_release cycle", qat(relqC, rC), 265);
    chk("A en_acc cycles, no restart", enCntA - en0, 264);
    chk("C clr_acc count", clrqC.size() - cC, 8);
    chk("C clr_acc first", qat(clrqC, cC), 4);
    chk("C clr_acc second", qat(clrqC, cC + 1), 37);

    // Re-arm: x_full 0 then 1 starts a new run at base 0.
    xfA = 1'b0;
    repeat (2) step();
    xfA = 1'b1;
    baseA = cyc;
    iA = gotA.size();
    exp1.delete();
    exp1.push_back(mk(35, 0, 15, 0));
    for (int r = 1; r <= 40; r++) begin
      step();
      if (r == 1) chk("rearm addr_x3", int'(axA[3]), 3);
      if (r == 2) chk("rearm clr_acc", int'(clrA), 1);
    end
    cmp_ev("A rearm", gotA, iA, exp1);

    // Back-pressure: op_space low at last tap of pass base=4 for 10 cycles.
    rstA = 1'b1;
    step();
    rstA = 1'b0;
    opA = 1'b1;
    baseA = cyc;
    iA = gotA.size(); rA = relqA.size(); en0 = enCntA;
    stall_err = 0;
    expA.delete();
    for (int n = 0; n < 8; n++)
      expA.push_back(mk(((n < 2) ? 35 : 45) + 33*n, 4*n, 15, (n == 7) ? 1 : 0));
    for (int r = 1; r <= 300; r++) begin
      step();
      if (r == 66) opA = 1'b0;
      if (r == 76) opA = 1'b1;
      if (r >= 68 && r <= 77 && enA) stall_err++;
      if (r == 67) chk("stall en_acc before window", int'(enA), 1);
      if (r == 78) chk("stall en_acc after window", int'(enA), 1);
      if (r == 76) chk("stall wait addr_x1", int'(axA[1]), 0);
      if (r == 77) begin
        chk("resume addr_x0", int'(axA[0]), 8);
        chk("resume addr_x1", int'(axA[1]), 9);
        chk("resume addr_f", int'(afA), 0);
      end
    end
    chk("stall en_acc during wait", stall_err, 0);
    cmp_ev("A stall", gotA, iA, expA);
    chk("stall x_release cycle", qat(relqA, rA), 275);
    chk("stall en_acc cycles", enCntA - en0, 264);

    // Reset at tap 20 of pass base=12, then restart with x_full still high.
    rstA = 1'b1;
    step();
    rstA = 1'b0;
    baseA = cyc;
    for (int r = 1; r <= 120; r++) begin
      step();
      if (r == 120) begin
        chk("abort addr_f", int'(afA), 20);
        chk("abort addr_x0", int'(axA[0]), 32);
        chk("abort en_acc", int'(enA), 1);
      end
    end
    rstA = 1'b1;
    #1;
    chk_zero_a("async reset");
    iA = gotA.size();
    repeat (3) step();
    chk("valid_op during reset", gotA.size() - iA, 0);
    rstA = 1'b0;
    baseA = cyc;
    iA = gotA.size();
    for (int r = 1; r <= 60; r++) begin
      step();
      if (r == 1) chk("restart addr_x1", int'(axA[1]), 1);
    end
    cmp_ev("A restart", gotA, iA, exp1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
